// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_pkg
//  Description : Shared definitions for the RV32I load/store unit: funct3
//                codes, FSM state encoding, default data width and a
//                funct3 legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Stores only have signed-width encodings; loads add the unsigned variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic legal;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~is_store;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Combinational load lane select plus sign/zero extension.
//                Byte picked by the full offset, halfword by offset[1].
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the access type.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            F3_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
            F3_W:    result = mem_rdata;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory-access stage of the multi-cycle RV32I core. Accepts
//                one load/store from execute, drives a word-wide req/ack
//                memory, steers store bytes into lanes and returns extended
//                load data. A stuck memory is abandoned after TIMEOUT_CYCLES.
//                Optional macro MISALIGNED_TRAP_EN: misaligned H/W accesses
//                are rejected with resp_err instead of being truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int              CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic [1:0]       off_q, off_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             is_store_q, is_store_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic [3:0]       req_be;
    logic [XLEN-1:0]  req_lane_wdata;
    logic             req_misaligned;
    logic [XLEN-1:0]  ext_rdata;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .mem_rdata (mem_rdata),
        .offset    (off_q),
        .funct3    (funct3_q),
        .result    (ext_rdata)
    );

    // Byte enables and replicated data by access size; halfwords sit on the
    // half-lane chosen by addr[1], so a halfword at offset 3 lands on 1100.
    always_comb begin
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_be         = 4'b0001 << req_addr[1:0];
                req_lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be         = 4'b0011 << {req_addr[1], 1'b0};
                req_lane_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGNED_TRAP_EN
    assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/ACCESS/RESP FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        cnt_next     = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d      = req_addr[1:0];
                    funct3_d   = req_funct3;
                    is_store_d = req_is_store;
                    cnt_d      = '0;
                    if (!f3_legal(req_is_store, req_funct3) || req_misaligned) begin
                        // Rejected requests never reach the memory.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_lane_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = is_store_q ? '0 : ext_rdata;
                end else if (cnt_next == TIMEOUT_LIMIT) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            funct3_q     <= '0;
            is_store_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign stall      = (req_valid & ~req_ready) | (state_q != ST_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire
